// File: rtl/cnn_loop_pkg.sv
// Shared definitions for the CNN loop-nest walker.
// Holds the FSM state encoding, the largest supported nest depth and the
// helper that maps a zero bound/stride onto one when the config is latched.
package cnn_loop_pkg;

  // Largest nest depth the walker is built for.
  localparam int unsigned MaxDims = 8;

  // FSM state encoding.
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StRun  = 1'b1;

  // A zero bound would give an empty level and a zero stride would never
  // advance, so both are treated as one.
  function automatic logic [31:0] norm_nonzero(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/cnn_loop_level.sv
// One level of the loop nest.
// Latches a normalised bound/stride on load, keeps the level index and
// flags the final value of the level combinationally.
// Ports:
//   clk_i, reset_i : clock, async active-high reset
//   load_i         : latch bound_i/stride_i and zero the index
//   clr_i          : zero the index (abort)
//   step_i         : advance this level by one stride
//   wrap_en_i      : allow the index to wrap to 0 when stepping on its last value
//   bound_i        : iteration limit (exclusive)
//   stride_i       : step size
//   idx_o          : current index
//   last_o         : index is at the final value of this level
module cnn_loop_level
  import cnn_loop_pkg::*;
#(
  parameter int unsigned width_p        = 8,
  parameter int unsigned stride_width_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_i,
  input  logic                      clr_i,
  input  logic                      step_i,
  input  logic                      wrap_en_i,
  input  logic [width_p-1:0]        bound_i,
  input  logic [stride_width_p-1:0] stride_i,
  output logic [width_p-1:0]        idx_o,
  output logic                      last_o
);

  logic [width_p-1:0]        bound_q, bound_d;
  logic [stride_width_p-1:0] stride_q, stride_d;
  logic [width_p-1:0]        idx_q, idx_d;
  logic [width_p:0]          sum;

  // One extra bit so idx + stride can never wrap to a small value.
  assign sum    = {1'b0, idx_q} + (width_p + 1)'(stride_q);
  assign last_o = (sum >= {1'b0, bound_q});
  assign idx_o  = idx_q;

  always_comb begin
    bound_d  = bound_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      bound_d  = width_p'(norm_nonzero(32'(bound_i)));
      stride_d = stride_width_p'(norm_nonzero(32'(stride_i)));
      idx_d    = '0;
    end else if (step_i) begin
      if (last_o) begin
        idx_d = wrap_en_i ? '0 : idx_q;
      end else begin
        idx_d = sum[width_p-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bound_q  <= width_p'(1);
      stride_q <= stride_width_p'(1);
      idx_q    <= '0;
    end else begin
      bound_q  <= bound_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/cnn_loop_nest.sv
// Multi-level CNN loop-nest walker.
// Walks dims_p loop levels (level 0 innermost) and presents one index tuple
// per accepted beat on a valid/yield handshake, with per-level last flags and
// a one-cycle done pulse after the final tuple is accepted.
// Ports:
//   clk_i, reset_i : clock, async active-high reset
//   start_i        : begin a run (sampled only in IDLE)
//   clear_i        : synchronous abort back to IDLE, no done pulse
//   bound_i        : per-level limits, level k at [k*width_p +: width_p]
//   stride_i       : per-level steps, level k at [k*stride_width_p +: stride_width_p]
//   yield_i        : consumer accepts the current tuple
//   busy_o/valid_o : high while running
//   idx_o          : current index tuple
//   last_o         : per-level final-value flags (0 when idle)
//   done_o         : pulse after the final accept
module cnn_loop_nest
  import cnn_loop_pkg::*;
#(
  parameter int unsigned dims_p         = 4,
  parameter int unsigned width_p        = 8,
  parameter int unsigned stride_width_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [dims_p*width_p-1:0]        bound_i,
  input  logic [dims_p*stride_width_p-1:0] stride_i,
  input  logic                             yield_i,
  output logic                             busy_o,
  output logic                             valid_o,
  output logic [dims_p*width_p-1:0]        idx_o,
  output logic [dims_p-1:0]                last_o,
  output logic                             done_o
);

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic              run;
  logic              accept;
  logic              final_accept;
  logic              load;
  logic              clr;
  logic [dims_p-1:0] last_raw;
  logic [dims_p-1:0] step;
  // inner_all[k] is high when every level below k sits on its last value.
  logic [dims_p:0]   inner_all;

  assign run          = (state_q == StRun);
  assign accept       = run & yield_i;
  assign final_accept = accept & inner_all[dims_p];

  always_comb begin
    inner_all[0] = 1'b1;
    for (int k = 0; k < int'(dims_p); k++) begin
      inner_all[k+1] = inner_all[k] & last_raw[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(dims_p); k++) begin
      step[k] = accept & inner_all[k] & ~clear_i;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
    if (clear_i) begin
      state_d = StIdle;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StRun;
            load    = 1'b1;
          end
        end
        StRun: begin
          if (final_accept) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < dims_p; k++) begin : g_level
    cnn_loop_level #(
      .width_p       (width_p),
      .stride_width_p(stride_width_p)
    ) u_level (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .load_i   (load),
      .clr_i    (clr),
      .step_i   (step[k]),
      .wrap_en_i(1'b1),
      .bound_i  (bound_i[k*width_p +: width_p]),
      .stride_i (stride_i[k*stride_width_p +: stride_width_p]),
      .idx_o    (idx_o[k*width_p +: width_p]),
      .last_o   (last_raw[k])
    );
  end

  assign busy_o  = run;
  assign valid_o = run;
  // Final-value flags only mean something while a tuple is presented.
  assign last_o  = last_raw & {dims_p{run}};
  assign done_o  = done_q;

endmodule

// File: tb/tb_cnn_loop_nest.sv
module tb_cnn_loop_nest;

  localparam int unsigned Dims = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 4;

  logic                 clk;
  logic                 reset_i;
  logic                 start_i;
  logic                 clear_i;
  logic [Dims*W-1:0]    bound_i;
  logic [Dims*SW-1:0]   stride_i;
  logic                 yield_i;
  logic                 busy_o;
  logic                 valid_o;
  logic [Dims*W-1:0]    idx_o;
  logic [Dims-1:0]      last_o;
  logic                 done_o;

  int n_cmp;
  int n_bad;

  cnn_loop_nest #(
    .dims_p        (Dims),
    .width_p       (W),
    .stride_width_p(SW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .clear_i (clear_i),
    .bound_i (bound_i),
    .stride_i(stride_i),
    .yield_i (yield_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .idx_o   (idx_o),
    .last_o  (last_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".valid"}, 32'(valid_o), 32'd0);
    chk({tag, ".busy"},  32'(busy_o),  32'd0);
    chk({tag, ".last"},  32'(last_o),  32'd0);
    chk({tag, ".idx"},   idx_o,        32'd0);
    chk({tag, ".done"},  32'(done_o),  32'(exp_done));
  endtask

  // Launch a run; config inputs are scrambled right after to prove latching.
  task automatic start_run(input logic [31:0] b, input logic [15:0] s);
    start_i  = 1'b1;
    bound_i  = b;
    stride_i = s;
    yield_i  = 1'b0;
    tick();
    start_i  = 1'b0;
    bound_i  = 32'hFFFF_FFFF;
    stride_i = 16'h0000;
  endtask

  // Check the presented tuple, then accept it.
  task automatic beat(input string tag, input logic [31:0] ei, input logic [3:0] el);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".idx"},   idx_o,        ei);
    chk({tag, ".last"},  32'(last_o),  32'(el));
    chk({tag, ".done"},  32'(done_o),  32'd0);
    yield_i = 1'b1;
    tick();
    yield_i = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    clear_i  = 1'b0;
    yield_i  = 1'b0;
    bound_i  = '0;
    stride_i = '0;
    #2;
    chk_idle("rst", 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    tick();
    chk_idle("idle", 1'b0);

    // Single level: bound 5 stride 2 -> 0,2,4
    start_run(32'h0101_0105, 16'h1112);
    beat("s0", 32'h0000_0000, 4'b1110);
    beat("s1", 32'h0000_0002, 4'b1110);
    beat("s2", 32'h0000_0004, 4'b1111);
    chk_idle("s_done", 1'b1);
    tick();
    chk_idle("s_after", 1'b0);

    // Nest bounds {3,2}; start_i during RUN must be ignored
    start_run(32'h0101_0203, 16'h1111);
    beat("n00", 32'h0000_0000, 4'b1100);
    start_i = 1'b1;
    bound_i = 32'h0101_0101;
    beat("n01", 32'h0000_0001, 4'b1100);
    start_i = 1'b0;
    beat("n02", 32'h0000_0002, 4'b1101);
    beat("n10", 32'h0000_0100, 4'b1110);
    beat("n11", 32'h0000_0101, 4'b1110);
    beat("n12", 32'h0000_0102, 4'b1111);
    chk_idle("n_done", 1'b1);
    tick();
    chk_idle("n_after", 1'b0);

    // Stall at tuple 01 for three cycles
    start_run(32'h0101_0203, 16'h1111);
    beat("st00", 32'h0000_0000, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold.valid", 32'(valid_o), 32'd1);
      chk("st_hold.idx",   idx_o,        32'h0000_0001);
    end
    beat("st01", 32'h0000_0001, 4'b1100);
    beat("st02", 32'h0000_0002, 4'b1101);
    beat("st10", 32'h0000_0100, 4'b1110);
    beat("st11", 32'h0000_0101, 4'b1110);
    beat("st12", 32'h0000_0102, 4'b1111);
    chk_idle("st_done", 1'b1);

    // Degenerate config, restarted in the done cycle
    start_run(32'h0000_0000, 16'h0000);
    beat("dg0", 32'h0000_0000, 4'b1111);
    chk_idle("dg_done", 1'b1);
    start_run(32'h0000_0000, 16'h0000);
    beat("dg1", 32'h0000_0000, 4'b1111);
    chk_idle("dg1_done", 1'b1);
    tick();

    // Boundary: bound 255 stride 15 -> 0..240, 17 tuples
    start_run(32'h0101_01FF, 16'h111F);
    for (int i = 0; i < 17; i++) begin
      beat("bw", 32'(i * 15), (i == 16) ? 4'b1111 : 4'b1110);
    end
    chk_idle("bw_done", 1'b1);
    tick();

    // Clear at tuple 4 of 6
    start_run(32'h0101_0203, 16'h1111);
    beat("c00", 32'h0000_0000, 4'b1100);
    beat("c01", 32'h0000_0001, 4'b1100);
    beat("c02", 32'h0000_0002, 4'b1101);
    chk("c10.idx", idx_o, 32'h0000_0100);
    clear_i = 1'b1;
    yield_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    yield_i = 1'b0;
    start_i = 1'b0;
    chk_idle("c_abort", 1'b0);
    tick();
    chk_idle("c_abort2", 1'b0);
    start_run(32'h0101_0102, 16'h1111);
    beat("cr0", 32'h0000_0000, 4'b1110);
    beat("cr1", 32'h0000_0001, 4'b1111);
    chk_idle("cr_done", 1'b1);
    tick();

    // Async reset mid-run, between clock edges
    start_run(32'h0101_0203, 16'h1111);
    beat("r00", 32'h0000_0000, 4'b1100);
    chk("r01.idx", idx_o, 32'h0000_0001);
    #2;
    reset_i = 1'b1;
    #1;
    chk_idle("r_async", 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    tick();
    chk_idle("r_after", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_loop_nest.md
Name: cnn_loop_nest

Overview:
- Parametrised successor to the single-level CNN counter.
- Walks a nest of dims_p loop levels (level 0 innermost), each with its own runtime bound and stride latched at start.
- Emits one index tuple per accepted beat through a valid/yield handshake, plus per-level last flags and a done pulse.
- Sits between the layer controller and the window/weight address generators, replacing chains of pulse-cascaded counters.

Parameters:
- dims_p, 4, number of loop levels (1..8)
- width_p, 8, bits per level index and per level bound
- stride_width_p, 4, bits per level stride

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a run; sampled only in IDLE
- clear_i  in  1  synchronous abort; returns to IDLE, no done pulse
- bound_i  in  dims_p*width_p  per-level iteration limit (level k at bits [k*width_p +: width_p])
- stride_i  in  dims_p*stride_width_p  per-level step
- yield_i  in  1  consumer accepts current tuple
- busy_o  out  1  high in RUN
- valid_o  out  1  tuple on idx_o is valid
- idx_o  out  dims_p*width_p  current index per level
- last_o  out  dims_p  level k is at its final value
- done_o  out  1  one-cycle pulse after final tuple accepted

Behaviour:
- Reset (async, active-high) gives state IDLE and all idx 0. Outputs: busy_o=0, valid_o=0, last_o=0, done_o=0.
- FSM states:
  - IDLE: on start_i, latch bound_i/stride_i, clear all idx to 0, go to RUN.
  - RUN: valid_o=1 and busy_o=1. The final tuple is accepted when valid_o & yield_i & all last_o; this moves to IDLE, and done_o=1 on the following cycle only.
  - clear_i in any state: go to IDLE next cycle, idx to 0, done_o=0. clear_i has priority over start_i and yield_i.
- Latency:
  - First tuple is valid the cycle after start_i.
  - One tuple per cycle while yield_i stays high.
  - valid_o=0 and done_o=1 in the cycle after the final accept. start_i in that cycle is honoured.
- Advance on each accept (valid_o & yield_i):
  - Level 0 always steps.
  - Level k steps only when last_o[j]=1 for all j<k.
  - A stepping level with last_o[k]=1 wraps to 0; otherwise idx += stride.
  - If yield_i=0, idx_o, last_o and valid_o hold (stall).
- last_o[k] = (idx_k + stride_k >= bound_k), evaluated combinationally from latched config.
  - The sum is formed in width_p+1 bits; no wrap-around overflow is permitted.
  - Last value of a level = largest multiple of stride below bound.
- Degenerate config, normalised when latched:
  - bound 0 is treated as 1 (the level takes only value 0).
  - stride 0 is treated as 1.
  - All bounds 1 gives exactly one tuple.
- start_i while in RUN is ignored. bound_i/stride_i changes after start are ignored.
- Reset mid-run: immediate return to IDLE outputs; no done pulse.
- Tuple count per run = product over k of ceil(bound_k/stride_k).

Decomposition:
- Package cnn_loop_pkg holds:
  - state enum {IDLE, RUN}
  - a function for normalising bound/stride
  - a constant for the maximum dims
- Sub-module cnn_loop_level holds one level:
  - latched bound/stride, idx register, and last compute
  - ports: step, wrap-enable, load
  - instantiated dims_p times by generate, with the step chain built as an AND of inner last flags.

Test Plan:
- Single level, dims_p=1: bound 5, stride 2, yield held 1 -> idx 0,2,4; last_o=1 on 4; done_o pulses the cycle after 4 is accepted; 3 tuples total.
- Nest dims_p=2: bounds {3,2}, strides {1,1} -> tuples (l1,l0) 00,01,02,10,11,12; last_o[1]=1 only on the final three tuples, together with last_o[0]=1 on 12; 6 valid beats, done once.
- Stall: same nest, yield_i low for 3 cycles at tuple 01 -> idx_o and valid_o hold at 01; sequence resumes unchanged; total accepts still 6.
- Degenerate: bound 0, stride 0 on every level -> single tuple all zeros with all last_o=1, then done_o.
- Boundary width: width_p=8, bound 255, stride 15 -> last value 240; no overflow wrap to small values; 17 tuples.
- Abort/reset: clear_i at tuple 4 of 6 -> IDLE next cycle, no done_o, a new start works; async reset_i mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
